// File: rtl/reg_seq_ctrl.sv
// reg_seq_ctrl: command-driven register sequencer.
// Accepts LOAD / UP / DOWN / ROTL commands and walks the datapath register
// through N single steps, then pulses DONE for one cycle.
// Optional build macro: REG_SEQ_CTRL_SAT_EN turns UP/DOWN into saturating
// steps (hold at all-ones / zero with STEP low); otherwise UP/DOWN wrap.
//
// Handshake: a command transfers on a rising CLK edge where CMD_VALID and
// CMD_READY are both 1. CMD_READY is high only in IDLE while RST=1, and it
// does not depend on CMD_VALID. CMD_OP/CMD_DATA/CMD_LEN are sampled only on
// that transfer edge. CMD_VALID in any other cycle is ignored and never
// queued.
module reg_seq_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNTW  = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CMD_VALID,
    output logic             CMD_READY,
    input  logic [1:0]       CMD_OP,
    input  logic [WIDTH-1:0] CMD_DATA,
    input  logic [CNTW-1:0]  CMD_LEN,
    output logic [WIDTH-1:0] Q,
    output logic             STEP,
    output logic             BUSY,
    output logic             DONE,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_UP   = 2'b01;
    localparam logic [1:0] OP_DOWN = 2'b10;
    localparam logic [1:0] OP_ROTL = 2'b11;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] q_q;
    logic [CNTW-1:0]  rem_q;
    logic [1:0]       op_q;
    logic             accept;
    logic             sat_hold;
    logic [WIDTH-1:0] step_val;

    assign accept = CMD_VALID & CMD_READY;

    // Saturation guard: true when the captured op would step past a limit.
    always_comb begin
`ifdef REG_SEQ_CTRL_SAT_EN
        sat_hold = ((op_q == OP_UP)   && (q_q == '1)) ||
                   ((op_q == OP_DOWN) && (q_q == '0));
`else
        sat_hold = 1'b0;
`endif
    end

    // Value Q takes after one RUN step of the captured op.
    always_comb begin
        step_val = q_q;
        if (!sat_hold) begin
            case (op_q)
                OP_UP:   step_val = q_q + WIDTH'(1);
                OP_DOWN: step_val = q_q - WIDTH'(1);
                OP_ROTL: step_val = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                default: step_val = q_q;
            endcase
        end
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if ((CMD_OP == OP_LOAD) || (CMD_LEN == '0)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (rem_q == CNTW'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs; every one is forced low while reset is asserted.
    always_comb begin
        CMD_READY = RST & (state_q == S_IDLE);
        BUSY      = RST & ((state_q == S_RUN) || (state_q == S_DONE));
        DONE      = RST & (state_q == S_DONE);
        STEP      = RST & (state_q == S_RUN) & ~sat_hold;
    end

    // Datapath: Q, remaining step count and captured op.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            q_q   <= '0;
            rem_q <= '0;
            op_q  <= OP_LOAD;
        end else if (accept) begin
            if (CMD_OP == OP_LOAD) begin
                q_q <= CMD_DATA;
            end else if (CMD_LEN != '0) begin
                op_q  <= CMD_OP;
                rem_q <= CMD_LEN;
            end
        end else if (state_q == S_RUN) begin
            q_q   <= step_val;
            rem_q <= rem_q - CNTW'(1);
        end
    end

    assign Q         = q_q;
    assign dbg_state = state_q;

endmodule
